// File: rtl/pbkdf2_u_accum_if.sv
// Handshake bundle between the SHA256 wrapper, the PBKDF2 message builder and
// the U_i accumulator: start/config, digest input, feedback and final T.
interface pbkdf2_u_accum_if #(
  parameter int CNT_W = 32
);
  logic             start_i;
  logic [CNT_W-1:0] cfg_iter_i;
  logic             start_ready_o;
  logic [255:0]     in;
  logic             in_valid;
  logic             in_ready;
  logic [255:0]     fb_out;
  logic             fb_valid;
  logic             fb_ready;
  logic [255:0]     out;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] iter_cnt_o;

  modport slave (
    input  start_i, cfg_iter_i, in, in_valid, fb_ready, out_ready,
    output start_ready_o, in_ready, fb_out, fb_valid, out, out_valid, iter_cnt_o
  );

  modport master (
    output start_i, cfg_iter_i, in, in_valid, fb_ready, out_ready,
    input  start_ready_o, in_ready, fb_out, fb_valid, out, out_valid, iter_cnt_o
  );
endinterface

// File: rtl/pbkdf2_u_accum.sv
// XOR-accumulates PBKDF2 HMAC results U_1..U_c into T, forwarding non-final U_i.
// Optional abort_i input is enabled by defining PBKDF2_ACCUM_ABORT_EN.
module pbkdf2_u_accum #(
  parameter int CNT_W = 32
) (
  input  logic clk_i,
  input  logic rst_ni,
`ifdef PBKDF2_ACCUM_ABORT_EN
  input  logic abort_i,
`endif
  pbkdf2_u_accum_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FEED  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [255:0]     acc_reg, acc_next;
  logic [255:0]     fb_reg, fb_next;
  logic [CNT_W-1:0] iter_cnt_reg, iter_cnt_next;
  logic [CNT_W-1:0] iter_tgt_reg, iter_tgt_next;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = iter_cnt_reg + CNT_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      fb_reg       <= '0;
      iter_cnt_reg <= '0;
      iter_tgt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      fb_reg       <= fb_next;
      iter_cnt_reg <= iter_cnt_next;
      iter_tgt_reg <= iter_tgt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    fb_next       = fb_reg;
    iter_cnt_next = iter_cnt_reg;
    iter_tgt_next = iter_tgt_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start_i) begin
          // c = 0 is treated as a single iteration
          iter_tgt_next = (bus.cfg_iter_i == '0) ? CNT_W'(1) : bus.cfg_iter_i;
          acc_next      = '0;
          iter_cnt_next = '0;
          state_next    = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.in_valid) begin
          acc_next      = acc_reg ^ bus.in;
          iter_cnt_next = cnt_inc;
          if (cnt_inc == iter_tgt_reg) begin
            state_next = DONE;
          end else begin
            fb_next    = bus.in;
            state_next = FEED;
          end
        end
      end
      FEED: begin
        if (bus.fb_ready) state_next = ACCUM;
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
`ifdef PBKDF2_ACCUM_ABORT_EN
    // Abort overrides whatever handshake the case above accepted this cycle
    if (abort_i && (state_reg != IDLE)) begin
      state_next    = IDLE;
      acc_next      = '0;
      fb_next       = '0;
      iter_cnt_next = '0;
    end
`endif
  end

  assign bus.start_ready_o = (state_reg == IDLE);
  assign bus.in_ready      = (state_reg == ACCUM);
  assign bus.fb_valid      = (state_reg == FEED);
  assign bus.out_valid     = (state_reg == DONE);
  assign bus.fb_out        = fb_reg;
  assign bus.out           = acc_reg;
  assign bus.iter_cnt_o    = iter_cnt_reg;

endmodule

// File: tb/tb_pbkdf2_u_accum.sv
// Scoreboard bench for pbkdf2_u_accum: directed cases plus randomized jobs with backpressure.
module tb_pbkdf2_u_accum;
  localparam int CNT_W = 32;

  typedef struct packed {
    logic [255:0] t;
    logic [31:0]  cnt;
  } out_exp_t;

  logic clk_i;
  logic rst_ni;
`ifdef PBKDF2_ACCUM_ABORT_EN
  logic abort_i;
`endif

  pbkdf2_u_accum_if #(.CNT_W(CNT_W)) bus ();

  pbkdf2_u_accum #(.CNT_W(CNT_W)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
`ifdef PBKDF2_ACCUM_ABORT_EN
    .abort_i(abort_i),
`endif
    .bus    (bus)
  );

  logic [255:0] exp_fb[$];
  out_exp_t     exp_out[$];
  logic [255:0] stim_q[$];
  int checks   = 0;
  int failures = 0;
  bit bp_rand  = 0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: compares every presented feedback/final block against the queue head
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (bus.fb_valid) begin
          check("fb_excludes_in_ready", {255'd0, bus.in_ready}, 256'd0);
          if (exp_fb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL fb_unexpected actual=%0h required=no_feedback", bus.fb_out);
          end else begin
            check("fb_out", bus.fb_out, exp_fb[0]);
            if (bus.fb_ready) void'(exp_fb.pop_front());
          end
        end
        if (bus.out_valid) begin
          if (exp_out.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL out_unexpected actual=%0h required=no_output", bus.out);
          end else begin
            check("out_T", bus.out, exp_out[0].t);
            check("out_iter_cnt", {224'd0, bus.iter_cnt_o}, {224'd0, exp_out[0].cnt});
            if (bus.out_ready) void'(exp_out.pop_front());
          end
        end
      end
    end
  end

  // Random backpressure on the two downstream ready inputs
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (bp_rand) begin
        bus.fb_ready  = 1'($urandom_range(0, 1));
        bus.out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic do_start(input logic [31:0] cfg);
    int n = 0;
    while (bus.start_ready_o !== 1'b1 && n < 200) begin
      @(posedge clk_i); #1; n++;
    end
    if (n >= 200) note_fail("start_timeout");
    bus.cfg_iter_i = cfg;
    bus.start_i    = 1'b1;
    @(posedge clk_i); #1;
    bus.start_i    = 1'b0;
    bus.cfg_iter_i = $urandom;
  endtask

  task automatic send_u(input logic [255:0] u, input bit is_final);
    int n = 0;
    bus.in       = u;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(posedge clk_i); #1; n++;
    end
    if (n >= 200) begin
      note_fail("in_accept_timeout");
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk_i); #1;
    bus.in_valid = 1'b0;
    bus.in       = rand256();
    if (is_final) check("out_valid_latency", {255'd0, bus.out_valid}, 256'd1);
    else          check("fb_valid_latency", {255'd0, bus.fb_valid}, 256'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_out.size() != 0 || exp_fb.size() != 0) && n < 500) begin
      @(posedge clk_i); #1; n++;
    end
    if (n >= 500) begin
      note_fail("drain_timeout");
      exp_out.delete();
      exp_fb.delete();
    end
  endtask

  // Reference: T is the XOR of all c digests; all but the last are fed back
  task automatic run_job(input logic [31:0] cfg);
    logic [31:0]  c;
    logic [255:0] t;
    logic [255:0] u;
    out_exp_t     e;
    c = (cfg == 0) ? 32'd1 : cfg;
    t = '0;
    do_start(cfg);
    for (int i = 0; i < int'(c); i++) begin
      u = (stim_q.size() != 0) ? stim_q.pop_front() : rand256();
      t = t ^ u;
      if (i < int'(c) - 1) begin
        exp_fb.push_back(u);
      end else begin
        e.t = t; e.cnt = c;
        exp_out.push_back(e);
      end
      send_u(u, i == int'(c) - 1);
    end
    wait_drain();
    $display("job cfg=%0d c=%0d T=%0h", cfg, c, t);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start_ready"}, {255'd0, bus.start_ready_o}, 256'd1);
    check({tag, "_in_ready"}, {255'd0, bus.in_ready}, 256'd0);
    check({tag, "_fb_valid"}, {255'd0, bus.fb_valid}, 256'd0);
    check({tag, "_out_valid"}, {255'd0, bus.out_valid}, 256'd0);
    check({tag, "_out"}, bus.out, 256'd0);
    check({tag, "_fb_out"}, bus.fb_out, 256'd0);
    check({tag, "_iter_cnt"}, {224'd0, bus.iter_cnt_o}, 256'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] u1, u2, a5;
    rst_ni         = 1'b0;
    bus.start_i    = 1'b0;
    bus.cfg_iter_i = '0;
    bus.in         = '0;
    bus.in_valid   = 1'b0;
    bus.fb_ready   = 1'b1;
    bus.out_ready  = 1'b1;
`ifdef PBKDF2_ACCUM_ABORT_EN
    abort_i = 1'b0;
`endif
    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // 1: single iteration, no feedback expected
    a5 = {32{8'hA5}};
    stim_q.push_back(a5);
    run_job(32'd1);

    // 2: c=3 with 1,2,4 -> feedback 1,2 and T = 7
    stim_q.push_back(256'h1); stim_q.push_back(256'h2); stim_q.push_back(256'h4);
    run_job(32'd3);

    // 3: c=2 with feedback stalled 10 cycles
    u1 = rand256(); u2 = rand256();
    bus.fb_ready = 1'b0;
    do_start(32'd2);
    exp_fb.push_back(u1);
    send_u(u1, 1'b0);
    bus.in = u2; bus.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("stall_fb_valid", {255'd0, bus.fb_valid}, 256'd1);
      check("stall_in_ready", {255'd0, bus.in_ready}, 256'd0);
      check("stall_fb_out", bus.fb_out, u1);
      @(posedge clk_i); #1;
    end
    check("stall_iter_cnt", {224'd0, bus.iter_cnt_o}, 256'd1);
    begin
      out_exp_t e;
      e.t = u1 ^ u2; e.cnt = 32'd2;
      exp_out.push_back(e);
    end
    bus.fb_ready = 1'b1;
    send_u(u2, 1'b1);
    wait_drain();
    $display("job stall c=2 T=%0h", u1 ^ u2);

    // 4: cfg_iter_i = 0 behaves as c = 1
    stim_q.push_back(256'hFF);
    run_job(32'd0);

    // 5: asynchronous reset in the middle of FEED
    u1 = rand256();
    bus.fb_ready = 1'b0;
    do_start(32'd4);
    exp_fb.push_back(u1);
    send_u(u1, 1'b0);
    check("pre_reset_iter_cnt", {224'd0, bus.iter_cnt_o}, 256'd1);
    @(posedge clk_i); #3;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_fb.delete();
    exp_out.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    bus.fb_ready = 1'b1;
    @(posedge clk_i); #1;
    stim_q.push_back(256'h3);
    run_job(32'd1);

`ifdef PBKDF2_ACCUM_ABORT_EN
    // 6: abort coincident with the second digest handshake
    begin
      int n = 0;
      u1 = rand256(); u2 = rand256();
      do_start(32'd5);
      exp_fb.push_back(u1);
      send_u(u1, 1'b0);
      bus.in = u2; bus.in_valid = 1'b1;
      while (bus.in_ready !== 1'b1 && n < 200) begin
        @(posedge clk_i); #1; n++;
      end
      if (n >= 200) note_fail("abort_setup_timeout");
      abort_i = 1'b1;
      @(posedge clk_i); #1;
      abort_i = 1'b0; bus.in_valid = 1'b0;
      check("abort_start_ready", {255'd0, bus.start_ready_o}, 256'd1);
      check("abort_iter_cnt", {224'd0, bus.iter_cnt_o}, 256'd0);
      check("abort_fb_valid", {255'd0, bus.fb_valid}, 256'd0);
      check("abort_out_valid", {255'd0, bus.out_valid}, 256'd0);
      check("abort_out", bus.out, 256'd0);
      wait_drain();
      stim_q.push_back(256'h9);
      run_job(32'd1);
    end
`endif

    // Randomized jobs with random downstream backpressure
    bp_rand = 1'b1;
    for (int j = 0; j < 10; j++) begin
      run_job(32'($urandom_range(0, 6)));
    end
    bp_rand = 1'b0;
    bus.fb_ready = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
